// File: rtl/fp_pkg.sv
// fp_pkg: shared classes, flag indices and format constants for the fp multiplier
// Contents: operand class enum, FLAGS bit positions, and constant functions that
// build BIAS, canonical quiet NaN and max-finite magnitude for any EXP_W/MAN_W.
package fp_pkg;

   typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} fp_cls_t;

   localparam int FLG_NV = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   function automatic int fp_bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // {0, all-ones exponent, fraction MSB set}
   function automatic logic [63:0] fp_qnan(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
   endfunction

   // magnitude bits only: {all-ones minus one exponent, all-ones fraction}
   function automatic logic [63:0] fp_maxfin(input int ew, input int mw);
      return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
   endfunction

endpackage

// File: rtl/fpm_sig_mul.sv
// fpm_sig_mul: combinational unsigned significand multiplier
// Ports:
//   a  in  N    multiplicand
//   b  in  N    multiplier
//   p  out 2N   full-width unsigned product
module fpm_sig_mul #(
   parameter int N = 11
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   assign p = (2*N)'(a) * (2*N)'(b);

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined floating-point multiplier with valid/ready flow control
// Ports:
//   CLK        in   1   clock
//   RESET      in   1   synchronous active-high reset
//   IN_VALID   in   1   operand pair valid
//   IN_READY   out  1   operands accepted this cycle
//   A, B       in   W   operands {sign, exp, frac}
//   RND        in   1   0 = round-nearest-even, 1 = round-toward-zero
//   OUT_VALID  out  1   result valid
//   OUT_READY  in   1   downstream accepts result
//   OUT        out  W   product
//   FLAGS      out  4   {NV, OF, UF, NX}
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     IN_VALID,
   output logic                     IN_READY,
   input  logic [EXP_W+MAN_W:0]     A,
   input  logic [EXP_W+MAN_W:0]     B,
   input  logic                     RND,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [EXP_W+MAN_W:0]     OUT,
   output logic [3:0]               FLAGS
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int EW2 = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam int BIAS = fp_bias(EXP_W);
   localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
   localparam logic [W-2:0] MAXFIN = (W-1)'(fp_maxfin(EXP_W, MAN_W));
   localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);

   function automatic fp_cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      return (e == '0) ? CLS_ZERO : (&e) ? ((f == '0) ? CLS_INF : CLS_NAN) : CLS_NORM;
   endfunction

   logic adv;
   logic v1, v2;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   fp_cls_t ca, cb;
   logic s1_sign, s1_rnd, s1_snan;
   logic signed [EW2-1:0] s1_e;
   fp_cls_t s1_ca, s1_cb;
   logic [MAN_W:0] s1_ma, s1_mb;
   logic s2_sign, s2_rnd, s2_snan;
   logic signed [EW2-1:0] s2_e;
   fp_cls_t s2_ca, s2_cb;
   logic [PW-1:0] prod, s2_prod;
   logic [PW-2:0] q;
   logic [MAN_W-1:0] frac, frac_r;
   logic guard, sticky, inc, carry, inf_zero;
   logic signed [EW2-1:0] e_fin;
   logic [W-1:0] res;
   logic [3:0] flg;

   // the whole pipe moves whenever the output register is free or being drained
   assign adv = !OUT_VALID | OUT_READY;
   assign IN_READY = adv;

   assign ea = A[W-2 -: EXP_W];
   assign eb = B[W-2 -: EXP_W];
   assign fa = A[MAN_W-1:0];
   assign fb = B[MAN_W-1:0];
   assign ca = classify(ea, fa);
   assign cb = classify(eb, fb);

   fpm_sig_mul #(.N(MAN_W + 1)) u_mul (.a(s1_ma), .b(s1_mb), .p(prod));

   always_ff @(posedge CLK) begin
      if (adv) begin
         s1_sign <= A[W-1] ^ B[W-1];
         s1_e    <= EW2'(ea) + EW2'(eb) - EW2'(BIAS);
         s1_ca   <= ca;
         s1_cb   <= cb;
         s1_ma   <= {1'b1, fa};
         s1_mb   <= {1'b1, fb};
         s1_rnd  <= RND;
         s1_snan <= (ca == CLS_NAN && !fa[MAN_W-1]) || (cb == CLS_NAN && !fb[MAN_W-1]);
         s2_sign <= s1_sign;
         s2_e    <= s1_e;
         s2_ca   <= s1_ca;
         s2_cb   <= s1_cb;
         s2_prod <= prod;
         s2_rnd  <= s1_rnd;
         s2_snan <= s1_snan;
      end
   end

   // normalise so the leading one sits just above q[PW-2]; then frac, guard, sticky follow
   always_comb begin
      q = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
      frac = q[PW-2 -: MAN_W];
      guard = q[MAN_W];
      sticky = |q[MAN_W-1:0];
      inc = !s2_rnd & guard & (sticky | frac[0]);
      {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(inc);
      e_fin = s2_e + EW2'(s2_prod[PW-1]) + EW2'(carry);
   end

   always_comb begin
      inf_zero = (s2_ca == CLS_INF && s2_cb == CLS_ZERO) || (s2_ca == CLS_ZERO && s2_cb == CLS_INF);
      res = {s2_sign, e_fin[EXP_W-1:0], frac_r};
      flg = '0;
      flg[FLG_NX] = guard | sticky;
      if (s2_ca == CLS_NAN || s2_cb == CLS_NAN || inf_zero) begin
         res = QNAN;
         flg = '0;
         flg[FLG_NV] = s2_snan | inf_zero;
      end else if (s2_ca == CLS_INF || s2_cb == CLS_INF) begin
         res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg = '0;
      end else if (s2_ca == CLS_ZERO || s2_cb == CLS_ZERO) begin
         res = {s2_sign, {(W-1){1'b0}}};
         flg = '0;
      end else if (e_fin >= EMAX) begin
         res = s2_rnd ? {s2_sign, MAXFIN} : {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg[FLG_OF] = 1'b1;
         flg[FLG_NX] = 1'b1;
      end else if (e_fin <= 0) begin
         res = {s2_sign, {(W-1){1'b0}}};
         flg[FLG_UF] = 1'b1;
         flg[FLG_NX] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         OUT_VALID <= 1'b0;
         OUT       <= '0;
         FLAGS     <= '0;
      end else if (adv) begin
         v1        <= IN_VALID;
         v2        <= v1;
         OUT_VALID <= v2;
         OUT       <= res;
         FLAGS     <= flg;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe (FP16) with a value-level reference model
module tb_fp_mult_pipe;

   typedef struct {
      logic [15:0] out;
      logic [3:0]  flg;
   } exp_t;

   logic CLK = 1'b0;
   logic RESET, IN_VALID, IN_READY, RND, OUT_VALID, OUT_READY;
   logic [15:0] A, B, OUT;
   logic [3:0] FLAGS;

   exp_t sb[$];
   exp_t cur;
   int checks = 0;
   int failures = 0;
   int n_out = 0;
   bit rand_rdy = 0;
   bit prev_stall = 0;
   logic [15:0] prev_out;
   logic [3:0] prev_flg;

   always #5 CLK = ~CLK;

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .RND(RND), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT(OUT), .FLAGS(FLAGS)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: exact integer product of the significands, rounded by comparing the
   // discarded remainder with half an ulp.
   function automatic logic [19:0] fp_ref(input logic [15:0] a, input logic [15:0] b, input logic rz);
      logic s;
      int ea, eb, fa, fb, e, sh;
      longint m, keep, rem, half;
      bit za, zb, ia, ib, na, nb, iz, nx;
      s = a[15] ^ b[15];
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      fa = int'(a[9:0]);
      fb = int'(b[9:0]);
      za = ea == 0;
      zb = eb == 0;
      ia = ea == 31 && fa == 0;
      ib = eb == 31 && fb == 0;
      na = ea == 31 && fa != 0;
      nb = eb == 31 && fb != 0;
      iz = (ia && zb) || (ib && za);
      if (na || nb || iz) return {(iz || (na && fa < 512) || (nb && fb < 512)), 3'b000, 16'h7E00};
      if (ia || ib) return {4'b0000, s, 15'h7C00};
      if (za || zb) return {4'b0000, s, 15'h0000};
      m = longint'(1024 + fa) * longint'(1024 + fb);
      sh = (m >= 64'sd2097152) ? 11 : 10;
      e = ea + eb - 15 + (sh - 10);
      keep = m >> sh;
      rem = m - (keep << sh);
      half = 64'sd1 << (sh - 1);
      nx = rem != 0;
      if (!rz && (rem > half || (rem == half && keep % 2 == 1))) keep++;
      if (keep == 2048) begin
         keep = 1024;
         e++;
      end
      if (e >= 31) return {4'b0101, s, rz ? 15'h7BFF : 15'h7C00};
      if (e <= 0) return {4'b0011, s, 15'h0000};
      return {3'b000, nx, s, 5'(e), 10'(keep)};
   endfunction

   function automatic logic [15:0] gen();
      logic [15:0] sp [7] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7D00, 16'h0001};
      return ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 6)] : 16'($urandom);
   endfunction

   // called at a negedge; returns at the negedge after the accepting edge, IN_VALID left high
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic r,
                        input logic [15:0] eo, input logic [3:0] ef);
      A = a;
      B = b;
      RND = r;
      IN_VALID = 1'b1;
      #1;
      for (int i = 0; i < 50 && !IN_READY; i++) begin
         @(negedge CLK);
         #1;
      end
      checks++;
      if (!IN_READY) begin
         failures++;
         $display("FAIL issue_timeout actual=stalled required=accepted");
      end else sb.push_back('{eo, ef});
      @(negedge CLK);
   endtask

   task automatic issue_rand();
      logic [15:0] a, b;
      logic r;
      logic [19:0] e;
      a = gen();
      b = gen();
      r = 1'($urandom_range(0, 1));
      e = fp_ref(a, b, r);
      issue(a, b, r, e[15:0], e[19:16]);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge CLK);
      @(negedge CLK);
      chk("drain_empty", 32'(sb.size()), 0);
   endtask

   task automatic latency(input string name);
      int cyc;
      cyc = 1;
      #1;
      while (!OUT_VALID && cyc < 20) begin
         @(negedge CLK);
         #1;
         cyc++;
      end
      chk(name, 32'(cyc), 3);
      @(negedge CLK);
   endtask

   always @(negedge CLK) if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);

   always @(negedge CLK) begin
      #2;
      if (RESET) prev_stall = 0;
      else begin
         if (prev_stall && OUT_VALID) begin
            chk("hold_out", 32'(OUT), 32'(prev_out));
            chk("hold_flags", 32'(FLAGS), 32'(prev_flg));
         end
         if (OUT_VALID && !OUT_READY) chk("in_ready_stall", 32'(IN_READY), 0);
         if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result actual=%h required=none", OUT);
            end else begin
               cur = sb.pop_front();
               chk("result", 32'(OUT), 32'(cur.out));
               chk("flags", 32'(FLAGS), 32'(cur.flg));
               n_out++;
            end
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_out = OUT;
         prev_flg = FLAGS;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      RESET = 1'b1;
      IN_VALID = 1'b0;
      A = '0;
      B = '0;
      RND = 1'b0;
      OUT_READY = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("reset_out_valid", 32'(OUT_VALID), 0);
      chk("reset_out", 32'(OUT), 0);
      chk("reset_flags", 32'(FLAGS), 0);
      RESET = 1'b0;
      @(negedge CLK);

      issue(16'h3E00, 16'h3E00, 1'b0, 16'h4080, 4'b0000);
      IN_VALID = 1'b0;
      latency("latency_first");
      issue(16'hC000, 16'h3C00, 1'b0, 16'hC000, 4'b0000);
      issue(16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'b0001);
      issue(16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'b0001);
      issue(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
      issue(16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 4'b0101);
      issue(16'h0400, 16'h3800, 1'b0, 16'h0000, 4'b0011);
      issue(16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000);
      issue(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
      issue(16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
      issue(16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'b0000);
      issue(16'h8000, 16'h3C00, 1'b0, 16'h8000, 4'b0000);
      IN_VALID = 1'b0;
      drain();

      n0 = n_out;
      fork
         for (int i = 0; i < 8; i++) issue_rand();
         begin
            repeat (3) @(negedge CLK);
            OUT_READY = 1'b0;
            repeat (5) @(negedge CLK);
            OUT_READY = 1'b1;
         end
      join
      IN_VALID = 1'b0;
      drain();
      chk("stream_count", 32'(n_out - n0), 8);

      issue_rand();
      issue_rand();
      IN_VALID = 1'b0;
      RESET = 1'b1;
      sb.delete();
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("reset_flush_valid", 32'(OUT_VALID), 0);
      @(negedge CLK);
      repeat (5) @(negedge CLK);
      issue(16'h3E00, 16'h3E00, 1'b0, 16'h4080, 4'b0000);
      IN_VALID = 1'b0;
      latency("latency_after_reset");
      drain();

      n0 = n_out;
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            IN_VALID = 1'b0;
            @(negedge CLK);
         end else issue_rand();
      end
      IN_VALID = 1'b0;
      rand_rdy = 0;
      OUT_READY = 1'b1;
      drain();
      chk("random_nonzero", 32'(n_out - n0 > 100), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
